switch_debouncer: RTL

- Input conditioner that sits directly upstream of the 4-input combinational logic block. It takes the raw board switches and drives that block's `sw[3:0]` bus.
- Each raw switch bit passes through a 2-flop synchronizer, then a per-bit stability counter.
- A bit's cleaned value changes only after the synchronized input has disagreed with it for STABLE_CYCLES consecutive clocks.
- Also emits a one-cycle change strobe and mask for downstream logging and LED logic.

---
 rtl/debounce_pkg.sv | 6 +
 rtl/debounce_bit.sv | 30 +++
 rtl/switch_debouncer.sv | 32 +++
 3 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared debounce constants for simulation and board builds
package debounce_pkg;
  localparam int DEFAULT_STABLE_CYCLES_SIM = 4;
  localparam int DEFAULT_STABLE_CYCLES_BOARD = 1000000;
  localparam int CLK_HZ = 100000000;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: 2-flop synchronizer plus stability counter for one switch bit
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES_SIM,
  parameter int CNT_W = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic q,
  output logic hit
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic s1, s2;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  always_ff @(posedge clk)
    if (reset) {s1, s2, q, cnt} <= '0;
    else begin
      s1  <= raw;
      s2  <= s1;
      q   <= hit ? s2 : q;
      cnt <= cnt_nxt;
    end
  // any agreeing cycle restarts the count, so bounces never accumulate
  always_comb begin
    hit     = (s2 != q) && (cnt == LAST);
    cnt_nxt = (s2 == q || hit) ? '0 : cnt + CNT_W'(1);
  end
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: per-bit debounced switches with registered change strobe and mask
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES_SIM,
  localparam int CNT_W = $clog2(STABLE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw,
  output logic             changed,
  output logic [WIDTH-1:0] changed_mask
);
  logic [WIDTH-1:0] hit;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_bit (
      .clk(clk),
      .reset(reset),
      .raw(sw_raw[i]),
      .q(sw[i]),
      .hit(hit[i])
    );
  end
  always_ff @(posedge clk)
    if (reset) {changed, changed_mask} <= '0;
    else begin
      changed_mask <= hit;
      changed      <= |hit;
    end
endmodule
